// File: rtl/pc_seq_pkg.sv
// Shared types for the next-PC sequencer: FSM states and PC-source encodings.
package pc_seq_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      IND_WAIT = 1'b1
   } seq_state_e;

   typedef enum logic [1:0] {
      PCS_SEQ  = 2'd0,
      PCS_TGT  = 2'd1,
      PCS_MEM  = 2'd2,
      PCS_HOLD = 2'd3
   } pc_src_e;

   // Width of a flag-select field; stays at least 1 bit for a single-flag build.
   function automatic int csel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Decode-op, indirect-memory and PC-status bundle of the next-PC sequencer.
interface pc_seq_ctrl_if
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int N_FLAGS = 4
) ();
   localparam int CSEL_W = csel_w(N_FLAGS);

   logic              op_valid;
   logic              op_ready;
   logic              op_br;
   logic              op_jmp;
   logic              op_jmi;
   logic              rel;
   logic [ADDR_W-1:0] target;
   logic [CSEL_W-1:0] cond_sel;
   logic              cond_inv;
   logic [N_FLAGS-1:0] flags;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [ADDR_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        pc_src;
   logic              redirect;

   modport master (
      output op_valid, op_br, op_jmp, op_jmi, rel, target, cond_sel, cond_inv, flags,
      output mem_ack, mem_rdata,
      input  op_ready, mem_req, mem_addr, pc, pc_src, redirect
   );

   modport slave (
      input  op_valid, op_br, op_jmp, op_jmi, rel, target, cond_sel, cond_inv, flags,
      input  mem_ack, mem_rdata,
      output op_ready, mem_req, mem_addr, pc, pc_src, redirect
   );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational branch/jump target and branch-condition evaluation.
module pc_target_calc #(
   parameter int ADDR_W  = 8,
   parameter int N_FLAGS = 4,
   parameter int CSEL_W  = 2
) (
   input  logic [ADDR_W-1:0]  pc,
   input  logic               rel,
   input  logic [ADDR_W-1:0]  target,
   input  logic [CSEL_W-1:0]  cond_sel,
   input  logic               cond_inv,
   input  logic [N_FLAGS-1:0] flags,
   output logic [ADDR_W-1:0]  eff,
   output logic               taken
);
   logic flag;

   // Offset already spans ADDR_W, so sign extension is a plain modular add.
   assign eff = rel ? (pc + target) : target;

   // Selects past the last flag read as 0.
   always_comb begin
      flag = 1'b0;
      for (int i = 0; i < N_FLAGS; i++)
         if (cond_sel == CSEL_W'(i)) flag = flags[i];
   end

   assign taken = flag ^ cond_inv;
endmodule

// File: rtl/pc_seq_ctrl.sv
// Registered next-PC sequencer with relative/absolute targets and memory-indirect jump.
// Optional taken-redirect counter enabled by defining PC_SEQ_TAKEN_CNT_EN.
module pc_seq_ctrl
   import pc_seq_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                N_FLAGS  = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   pc_seq_ctrl_if.slave bus
`ifdef PC_SEQ_TAKEN_CNT_EN
   ,
   output logic [15:0]  taken_cnt
`endif
);
   localparam int CSEL_W = csel_w(N_FLAGS);

   seq_state_e        state;
   pc_src_e           src_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] addr_q;
   logic              req_q;
   logic              redir_q;
   logic [ADDR_W-1:0] eff;
   logic              taken;

   pc_target_calc #(
      .ADDR_W (ADDR_W),
      .N_FLAGS(N_FLAGS),
      .CSEL_W (CSEL_W)
   ) u_tgt (
      .pc      (pc_q),
      .rel     (bus.rel),
      .target  (bus.target),
      .cond_sel(bus.cond_sel),
      .cond_inv(bus.cond_inv),
      .flags   (bus.flags),
      .eff     (eff),
      .taken   (taken)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         pc_q    <= RESET_PC;
         src_q   <= PCS_SEQ;
         redir_q <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         redir_q <= 1'b0;
         case (state)
            RUN: begin
               // Indirect beats jump beats branch when several op bits are set.
               if (bus.op_valid && bus.op_jmi) begin
                  addr_q <= eff;
                  req_q  <= 1'b1;
                  src_q  <= PCS_HOLD;
                  state  <= IND_WAIT;
               end else if (bus.op_valid && (bus.op_jmp || (bus.op_br && taken))) begin
                  pc_q    <= eff;
                  src_q   <= PCS_TGT;
                  redir_q <= 1'b1;
               end else begin
                  pc_q  <= pc_q + ADDR_W'(1);
                  src_q <= PCS_SEQ;
               end
            end
            IND_WAIT: begin
               if (bus.mem_ack) begin
                  pc_q    <= bus.mem_rdata;
                  src_q   <= PCS_MEM;
                  redir_q <= 1'b1;
                  req_q   <= 1'b0;
                  state   <= RUN;
               end else begin
                  src_q <= PCS_HOLD;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.op_ready = (state == RUN);
   assign bus.mem_req  = req_q;
   assign bus.mem_addr = addr_q;
   assign bus.pc       = pc_q;
   assign bus.pc_src   = src_q;
   assign bus.redirect = redir_q;

`ifdef PC_SEQ_TAKEN_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (redir_q && cnt_q != 16'hFFFF)
         cnt_q <= cnt_q + 16'd1;
   end

   assign taken_cnt = cnt_q;
`endif
endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Parametrised next-PC sequencer for the small teaching CPU. Generalises the flag-driven PC source select (branch-on-N, branch-on-Z, jump, jump-via-memory) into a registered PC with selectable condition flags, relative/absolute targets and a multi-cycle memory-indirect jump using a req/ack handshake. Sits between instruction decode and the instruction-fetch address port.

Parameters:
ADDR_W, 8, PC/target/memory data width in bits (>=4)
N_FLAGS, 4, number of ALU condition flags visible to branches (N,Z,C,V at default)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  decoded control-flow op present this cycle
op_ready  out  1  unit can accept an op (high in RUN only)
op_br  in  1  conditional branch
op_jmp  in  1  unconditional jump
op_jmi  in  1  jump indirect: new PC read from memory at target
rel  in  1  1 = target is signed offset from current PC, 0 = absolute
target  in  ADDR_W  branch/jump address or offset
cond_sel  in  $clog2(N_FLAGS)  flag index tested by op_br
cond_inv  in  1  invert tested flag
flags  in  N_FLAGS  ALU condition flags
mem_req  out  1  indirect read request
mem_addr  out  ADDR_W  indirect read address
mem_ack  in  1  read data valid
mem_rdata  in  ADDR_W  read data
pc  out  ADDR_W  current PC (registered)
pc_src  out  2  source of last PC update: 0 seq, 1 target, 2 memory, 3 hold
redirect  out  1  one-cycle pulse: PC changed non-sequentially on last edge

Behaviour:
- Reset (async, rst_n=0): state RUN, pc=RESET_PC, pc_src=0, redirect=0, mem_req=0, mem_addr=0; outputs change without a clock edge.
- States: RUN, IND_WAIT. op_ready = (state==RUN).
- RUN, op_valid=0: pc <= pc+1 mod 2^ADDR_W, pc_src<=0.
- RUN, op_valid=1, priority op_jmi > op_jmp > op_br when several set:
  - eff = rel ? pc + sext(target) (mod 2^ADDR_W) : target.
  - op_br: taken = flags[cond_sel] ^ cond_inv; taken -> pc<=eff, pc_src<=1, redirect<=1; not taken -> pc<=pc+1, pc_src<=0.
  - op_jmp: pc<=eff, pc_src<=1, redirect<=1.
  - op_jmi: mem_addr<=eff, mem_req<=1, pc held, pc_src<=3, state->IND_WAIT.
  - no op bit set with op_valid=1: treated as sequential.
- IND_WAIT: mem_req stays 1, mem_addr stable until mem_ack; pc held, pc_src=3 each cycle. On mem_ack: pc<=mem_rdata, pc_src<=2, redirect<=1, mem_req<=0, ->RUN. Ops presented during IND_WAIT are ignored (op_ready=0). No timeout.
- redirect registered, high exactly one cycle after each non-sequential update, else 0.
- Latency: branch/jump 1 cycle; indirect = 1 + cycles to mem_ack (min 2 cycles, ack in first IND_WAIT cycle).
- Reset during IND_WAIT: request abandoned, mem_req drops asynchronously, any later mem_ack ignored.
- cond_sel >= N_FLAGS: branch not taken (cond_inv still applied to a 0 flag).

Optional Feature:
Macro PC_SEQ_TAKEN_CNT_EN. Defined: extra output taken_cnt [15:0], increments on each redirect pulse, saturates at 16'hFFFF, cleared by reset. Undefined: port and counter absent, behaviour otherwise identical.

Decomposition:
- Package pc_seq_pkg: state enum (RUN, IND_WAIT), pc_src encodings (PCS_SEQ=0, PCS_TGT=1, PCS_MEM=2, PCS_HOLD=3).
- One sub-module pc_target_calc: combinational eff-address and branch-taken evaluation. FSM, PC register and optional counter stay in top.

Test Plan:
- Reset release, RESET_PC=0, no ops, 260 cycles -> pc 0,1,...,255,0,1,... wraps, pc_src=0, redirect=0 throughout.
- pc=8'h10, op_br, cond_sel=1, flags=4'b0010, cond_inv=0, rel=1, target=8'hFC -> next pc=8'h0C, pc_src=1, redirect one cycle; same with cond_inv=1 -> pc=8'h11.
- op_jmp with op_br and op_jmi=0, rel=0, target=8'h40 -> pc=8'h40, pc_src=1; op_jmp and op_jmi both set -> indirect path wins.
- op_jmi, target=8'h80, mem_ack after 3 cycles with mem_rdata=8'h5A -> mem_req high 3 cycles, mem_addr=8'h80, pc held, op_ready=0, then pc=8'h5A, pc_src=2, redirect pulse.
- rst_n low in 2nd IND_WAIT cycle -> mem_req 0 immediately, pc=RESET_PC; later mem_ack ignored, pc counts from RESET_PC.
- With PC_SEQ_TAKEN_CNT_EN: 5 taken branches, 3 not-taken, 1 indirect -> taken_cnt=6; preload near saturation via 65540 jumps -> holds 16'hFFFF.
